id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the five-stage RISC-V core. It sits directly downstream of the opcode decoder and captures the decoder's control bundle together with the ID-stage operands and register indices, then presents them to EX one cycle later. It also contains load-use hazard detection: it inserts bubbles and drives the stall request back to PC/IF-ID. A saturating counter records how many bubbles were inserted.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hold_i  in  1  global freeze from the memory system; the register keeps its contents.
- flush_i  in  1  squash from EX (taken branch or jump); the next load is a bubble.
- id_valid_i  in  1  the ID stage holds a real instruction.
- id_opcode_i  in  7  opcode of the ID instruction; used for hazard detection.
- id_aluop_i, id_memtoreg_i, id_jump_i  in  2 each  decoder controls.
- id_memread_i, id_memwrite_i, id_regwrite_i, id_alusrc_i, id_luiorauipc_i  in  1 each  decoder controls.
- id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN each  ID data.
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices.
- id_funct3_i  in  3  funct3 field; id_funct7b5_i  in  1  instruction bit 30.
- ex_*_o  out  widths matching the corresponding id_*_i  registered copies for EX.
- ex_valid_o  out  1  the EX slot holds a real instruction.
- stall_o  out  1  load-use stall request to the PC and IF/ID registers.
- bubble_cnt_o  out  CNT_W  number of load-use bubbles inserted, saturating.

## Operation
- Source register usage, decoded from id_opcode_i:
  - uses_rs1 = 1 for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - uses_rs2 = 1 only for R-type 0110011, STORE 0100011 and BRANCH 1100011.
  - Unknown opcodes use neither source.
- hazard = ex_valid_o & ex_memread_o & (ex_rd_o != 0) & id_valid_i & ((uses_rs1 & ex_rd_o == id_rs1_i) | (uses_rs2 & ex_rd_o == id_rs2_i)).
- stall_o = hazard & ~flush_i. A flushed ID instruction never stalls.
- Per-edge action, evaluated in priority order:
  1. rst_n low: clear all outputs.
  2. hold_i = 1: keep every register and the counter. A flush_i seen while hold_i = 1 is not remembered; EX keeps flush_i asserted until hold_i drops.
  3. flush_i = 1: load a bubble.
  4. hazard = 1: load a bubble and increment the counter.
  5. Otherwise: load all id_* fields; ex_valid_o <= id_valid_i.
- Bubble definition:
  - ex_valid_o = 0.
  - ex_memread_o, ex_memwrite_o and ex_regwrite_o are 0; ex_jump_o = 00; ex_memtoreg_o = 00; ex_aluop_o = 00; ex_alusrc_o = 0; ex_luiorauipc_o = 0.
  - Data fields and indices still capture the ID inputs; they are don't-care.
- When id_valid_i = 0 and the load path is taken, the decoder controls are still zeroed as for a bubble. No side effect may come from an invalid slot.
- Counter: increments by 1 per bubble caused by hazard; flush bubbles are not counted. It saturates at all-ones and never wraps.
- A control input carrying X from the decoder is captured unchanged on the load path. Bubbles always force known zeros.

## Timing
- Reset values: every ex_*_o = 0, ex_valid_o = 0, bubble_cnt_o = 0. stall_o is 0 because ex_valid_o = 0.
- Latency: ID inputs appear on ex_*_o one cycle after a load edge.
- stall_o is combinational from the current ex_* registers and the id_* inputs, and is valid in the same cycle.
- A single load-use pair costs exactly one bubble cycle:
  - Cycle n: stall_o = 1.
  - Edge n+1: bubble loaded, so stall_o drops because ex_memread_o = 0.
  - Edge n+2: the dependent instruction loads.
- hold_i freezes stall_o at its current value, because the inputs are frozen upstream as well.
- An asynchronous reset asserted mid-stall clears the outputs immediately. After rst_n rises, the first edge loads normally.

## Test plan
- Reset: drive rst_n low mid-cycle -> all outputs read 0 without waiting for an edge; bubble_cnt_o = 0.
- Pass-through: id_opcode 0110011, regwrite = 1, aluop = 10, rd = 5, rs1_data = 0x11 -> next cycle ex_regwrite_o = 1, ex_aluop_o = 10, ex_rd_o = 5, ex_rs1_data_o = 0x11, ex_valid_o = 1.
- Load-use: EX holds a load with rd = 3; ID is an R-type with rs2 = 3 -> stall_o = 1; next cycle ex_valid_o = 0, ex_regwrite_o = 0, bubble_cnt_o = 1; the cycle after, the R-type appears in EX.
- No false hazard:
  - EX load with rd = 0 and ID rs1 = 0 -> stall_o = 0.
  - EX load with rd = 4 and ID LUI whose rs1 field = 4 -> stall_o = 0.
- Flush priority: flush_i = 1 together with a hazard -> stall_o = 0, a bubble is loaded, and the counter is unchanged.
- Hold and saturation:
  - hold_i = 1 for 3 cycles with changing ID inputs -> ex_* outputs are unchanged.
  - Counter preloaded to 0xFFFF by 65535 hazards, then one more hazard -> it stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoder control bundle, the ID operands and the register
// indices, and presents them to EX one cycle later. When the instruction in
// EX is a load whose destination feeds the ID instruction, the stage asks
// PC/IF-ID to stall and loads a bubble. A saturating counter tracks how many
// hazard bubbles were inserted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hold_i              freeze every register (memory-system stall)
//   flush_i             squash: next load is a bubble, never stalls
//   id_valid_i          ID slot holds a real instruction
//   id_opcode_i         ID opcode, drives source-usage decode
//   id_<ctrl>_i         decoder controls (aluop, memtoreg, jump, memread,
//                       memwrite, regwrite, alusrc, luiorauipc)
//   id_<data>_i         pc, rs1/rs2 data, imm, rs1/rs2/rd, funct3, funct7b5
//   ex_*_o              registered copies of the id_* fields for EX
//   ex_valid_o          EX slot holds a real instruction
//   stall_o             load-use stall request (combinational)
//   bubble_cnt_o        saturating count of hazard bubbles
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [1:0]       id_aluop_i,
    input  logic [1:0]       id_memtoreg_i,
    input  logic [1:0]       id_jump_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             id_regwrite_i,
    input  logic             id_alusrc_i,
    input  logic             id_luiorauipc_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [2:0]       id_funct3_i,
    input  logic             id_funct7b5_i,
    output logic [6:0]       ex_opcode_o,
    output logic [1:0]       ex_aluop_o,
    output logic [1:0]       ex_memtoreg_o,
    output logic [1:0]       ex_jump_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             ex_regwrite_o,
    output logic             ex_alusrc_o,
    output logic             ex_luiorauipc_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [2:0]       ex_funct3_o,
    output logic             ex_funct7b5_o,
    output logic             ex_valid_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Controls are the fields a bubble must force to zero.
    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] memtoreg;
        logic [1:0] jump;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       alusrc;
        logic       luiorauipc;
    } ctrl_t;

    // Data fields are captured on every non-held edge, bubble or not.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
    } data_t;

    ctrl_t            id_ctrl, ctrl_d, ctrl_q;
    data_t            id_data, data_d, data_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             uses_rs1, uses_rs2, hazard, load_ok;

    assign id_ctrl = {id_aluop_i, id_memtoreg_i, id_jump_i, id_memread_i,
                      id_memwrite_i, id_regwrite_i, id_alusrc_i, id_luiorauipc_i};
    assign id_data = {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_opcode_i,
                      id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i};

    // Unknown opcodes read neither source, so they can never stall.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode_i)
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD, OP_FENCE, OP_IMM, OP_JALR, OP_SYSTEM: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = valid_q & ctrl_q.memread & (data_q.rd != 5'd0) & id_valid_i &
                    ((uses_rs1 & (data_q.rd == id_rs1_i)) |
                     (uses_rs2 & (data_q.rd == id_rs2_i)));
    assign stall_o = hazard & ~flush_i;

    // Controls pass only for a real, unsquashed, non-stalled instruction;
    // anything else becomes a bubble with known-zero controls.
    assign load_ok = id_valid_i & ~flush_i & ~hazard;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!hold_i) begin
            data_d  = id_data;
            valid_d = load_ok;
            ctrl_d  = load_ok ? id_ctrl : '0;
            if (hazard && !flush_i && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_aluop_o      = ctrl_q.aluop;
    assign ex_memtoreg_o   = ctrl_q.memtoreg;
    assign ex_jump_o       = ctrl_q.jump;
    assign ex_memread_o    = ctrl_q.memread;
    assign ex_memwrite_o   = ctrl_q.memwrite;
    assign ex_regwrite_o   = ctrl_q.regwrite;
    assign ex_alusrc_o     = ctrl_q.alusrc;
    assign ex_luiorauipc_o = ctrl_q.luiorauipc;
    assign ex_pc_o         = data_q.pc;
    assign ex_rs1_data_o   = data_q.rs1_data;
    assign ex_rs2_data_o   = data_q.rs2_data;
    assign ex_imm_o        = data_q.imm;
    assign ex_opcode_o     = data_q.opcode;
    assign ex_rs1_o        = data_q.rs1;
    assign ex_rs2_o        = data_q.rs2;
    assign ex_rd_o         = data_q.rd;
    assign ex_funct3_o     = data_q.funct3;
    assign ex_funct7b5_o   = data_q.funct7b5;
    assign ex_valid_o      = valid_q;
    assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int SW = 4;   // narrow counter copy, so saturation is reachable quickly

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, hold, flush, id_valid;
    logic [6:0]  id_opcode;
    logic [1:0]  id_aluop, id_memtoreg, id_jump;
    logic        id_memread, id_memwrite, id_regwrite, id_alusrc, id_lui;
    logic [31:0] id_pc, id_rs1d, id_rs2d, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_f3;
    logic        id_f7;

    logic [6:0]  ex_opcode;
    logic [1:0]  ex_aluop, ex_memtoreg, ex_jump;
    logic        ex_memread, ex_memwrite, ex_regwrite, ex_alusrc, ex_lui;
    logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_f3;
    logic        ex_f7, ex_valid, stall;
    logic [15:0] cnt;

    // second copy: only its counter is of interest
    logic [6:0]  s_opcode;
    logic [1:0]  s_aluop, s_memtoreg, s_jump;
    logic        s_memread, s_memwrite, s_regwrite, s_alusrc, s_lui;
    logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_f3;
    logic        s_f7, s_valid, s_stall;
    logic [SW-1:0] s_cnt;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
        .id_opcode_i(id_opcode), .id_aluop_i(id_aluop), .id_memtoreg_i(id_memtoreg),
        .id_jump_i(id_jump), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .id_regwrite_i(id_regwrite), .id_alusrc_i(id_alusrc), .id_luiorauipc_i(id_lui),
        .id_pc_i(id_pc), .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_funct3_i(id_f3),
        .id_funct7b5_i(id_f7),
        .ex_opcode_o(ex_opcode), .ex_aluop_o(ex_aluop), .ex_memtoreg_o(ex_memtoreg),
        .ex_jump_o(ex_jump), .ex_memread_o(ex_memread), .ex_memwrite_o(ex_memwrite),
        .ex_regwrite_o(ex_regwrite), .ex_alusrc_o(ex_alusrc), .ex_luiorauipc_o(ex_lui),
        .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1d), .ex_rs2_data_o(ex_rs2d), .ex_imm_o(ex_imm),
        .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_funct3_o(ex_f3),
        .ex_funct7b5_o(ex_f7), .ex_valid_o(ex_valid), .stall_o(stall), .bubble_cnt_o(cnt)
    );

    id_ex_stage #(.CNT_W(SW)) dut_s (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
        .id_opcode_i(id_opcode), .id_aluop_i(id_aluop), .id_memtoreg_i(id_memtoreg),
        .id_jump_i(id_jump), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .id_regwrite_i(id_regwrite), .id_alusrc_i(id_alusrc), .id_luiorauipc_i(id_lui),
        .id_pc_i(id_pc), .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_funct3_i(id_f3),
        .id_funct7b5_i(id_f7),
        .ex_opcode_o(s_opcode), .ex_aluop_o(s_aluop), .ex_memtoreg_o(s_memtoreg),
        .ex_jump_o(s_jump), .ex_memread_o(s_memread), .ex_memwrite_o(s_memwrite),
        .ex_regwrite_o(s_regwrite), .ex_alusrc_o(s_alusrc), .ex_luiorauipc_o(s_lui),
        .ex_pc_o(s_pc), .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d), .ex_imm_o(s_imm),
        .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd), .ex_funct3_o(s_f3),
        .ex_funct7b5_o(s_f7), .ex_valid_o(s_valid), .stall_o(s_stall), .bubble_cnt_o(s_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [1:0]  aluop, memtoreg, jump;
        logic        memread, memwrite, regwrite, alusrc, lui;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [6:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } ex_t;

    ex_t m;
    int  m_bubbles;     // unbounded count; each DUT copy sees it clamped
    int  n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0001111, 7'b0010011, 7'b0100011,
                          7'b0110011, 7'b1100011, 7'b1100111, 7'b1110011};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit m_hazard();
        return m.valid && m.memread && (m.rd != 0) && id_valid &&
               ((reads_rs1(id_opcode) && m.rd == id_rs1) ||
                (reads_rs2(id_opcode) && m.rd == id_rs2));
    endfunction

    function automatic logic [127:0] m_ctrl();
        return {m.valid, m.aluop, m.memtoreg, m.jump, m.memread, m.memwrite, m.regwrite,
                m.alusrc, m.lui, m.op, m.rs1, m.rs2, m.rd, m.f3, m.f7};
    endfunction

    function automatic logic [127:0] dut_ctrl();
        return {ex_valid, ex_aluop, ex_memtoreg, ex_jump, ex_memread, ex_memwrite, ex_regwrite,
                ex_alusrc, ex_lui, ex_opcode, ex_rs1, ex_rs2, ex_rd, ex_f3, ex_f7};
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_bubbles = 0;
    endtask

    task automatic take_id_fields();
        m.pc = id_pc; m.rs1d = id_rs1d; m.rs2d = id_rs2d; m.imm = id_imm;
        m.op = id_opcode; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
        m.f3 = id_f3; m.f7 = id_f7;
    endtask

    task automatic zero_controls();
        m.valid = 0; m.aluop = 0; m.memtoreg = 0; m.jump = 0;
        m.memread = 0; m.memwrite = 0; m.regwrite = 0; m.alusrc = 0; m.lui = 0;
    endtask

    task automatic model_edge();
        bit h;
        h = m_hazard();
        if (hold) return;
        take_id_fields();
        if (flush) zero_controls();
        else if (h) begin
            zero_controls();
            m_bubbles++;
        end else if (!id_valid) zero_controls();
        else begin
            m.valid = 1; m.aluop = id_aluop; m.memtoreg = id_memtoreg; m.jump = id_jump;
            m.memread = id_memread; m.memwrite = id_memwrite; m.regwrite = id_regwrite;
            m.alusrc = id_alusrc; m.lui = id_lui;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctrl"}, dut_ctrl(), m_ctrl());
        check({tag, ".data"}, {ex_pc, ex_rs1d, ex_rs2d, ex_imm}, {m.pc, m.rs1d, m.rs2d, m.imm});
        check({tag, ".cnt"}, 128'(cnt), 128'((m_bubbles > 65535) ? 65535 : m_bubbles));
        check({tag, ".cnt_s"}, 128'(s_cnt), 128'((m_bubbles > 15) ? 15 : m_bubbles));
    endtask

    // Called at a falling edge with inputs already applied: checks stall,
    // clocks one rising edge, then checks the registered outputs.
    task automatic step(input string tag);
        #1;
        check({tag, ".stall"}, 128'(stall), 128'(m_hazard() && !flush));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic id_clear();
        hold = 0; flush = 0; id_valid = 0; id_opcode = 0; id_aluop = 0; id_memtoreg = 0;
        id_jump = 0; id_memread = 0; id_memwrite = 0; id_regwrite = 0; id_alusrc = 0;
        id_lui = 0; id_pc = 0; id_rs1d = 0; id_rs2d = 0; id_imm = 0; id_rs1 = 0;
        id_rs2 = 0; id_rd = 0; id_f3 = 0; id_f7 = 0;
    endtask

    task automatic id_instr(input logic [6:0] op, input logic mr, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd);
        id_clear();
        id_valid = 1; id_opcode = op; id_memread = mr; id_regwrite = 1;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = $urandom; id_imm = $urandom; id_rs1d = $urandom; id_rs2d = $urandom;
    endtask

    task automatic id_random();
        logic [6:0] ops [11];
        ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1111111};
        id_opcode   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
        id_memread  = (id_opcode == 7'b0000011) ? 1'b1 : ($urandom_range(0, 7) == 0);
        id_valid    = ($urandom_range(0, 7) != 0);
        hold        = ($urandom_range(0, 7) == 0);
        flush       = ($urandom_range(0, 7) == 0);
        id_aluop    = 2'($urandom); id_memtoreg = 2'($urandom); id_jump = 2'($urandom);
        id_memwrite = 1'($urandom); id_regwrite = 1'($urandom);
        id_alusrc   = 1'($urandom); id_lui = 1'($urandom);
        id_pc = $urandom; id_rs1d = $urandom; id_rs2d = $urandom; id_imm = $urandom;
        id_rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        id_f3 = 3'($urandom); id_f7 = 1'($urandom);
    endtask

    localparam logic [6:0] LOAD = 7'b0000011, RTYPE = 7'b0110011, OPIMM = 7'b0010011,
                           LUI = 7'b0110111;

    initial begin
        logic [127:0] snap_c, snap_d;
        id_clear();
        model_reset();
        rst_n = 0;
        #12;
        check("reset.ctrl", dut_ctrl(), 128'd0);
        check("reset.cnt", 128'(cnt), 128'd0);
        @(negedge clk);
        rst_n = 1;

        // pass-through
        id_clear();
        id_valid = 1; id_opcode = RTYPE; id_regwrite = 1; id_aluop = 2'b10;
        id_rd = 5; id_rs1d = 32'h11;
        step("pass");
        check("pass.regwrite", 128'(ex_regwrite), 128'd1);
        check("pass.aluop", 128'(ex_aluop), 128'd2);
        check("pass.rd", 128'(ex_rd), 128'd5);
        check("pass.rs1d", 128'(ex_rs1d), 128'h11);
        check("pass.valid", 128'(ex_valid), 128'd1);

        // load-use: one bubble, then the dependent op
        id_instr(LOAD, 1, 1, 0, 3);
        step("lu.load");
        id_instr(RTYPE, 0, 1, 3, 6);
        #1 check("lu.stall_hi", 128'(stall), 128'd1);
        step("lu.bubble");
        check("lu.bub_valid", 128'(ex_valid), 128'd0);
        check("lu.bub_regwr", 128'(ex_regwrite), 128'd0);
        check("lu.bub_cnt", 128'(cnt), 128'd1);
        check("lu.stall_lo", 128'(stall), 128'd0);
        step("lu.dep");
        check("lu.dep_valid", 128'(ex_valid), 128'd1);
        check("lu.dep_rd", 128'(ex_rd), 128'd6);

        // no false hazards
        id_instr(LOAD, 1, 2, 0, 0);
        step("nf.load_x0");
        id_instr(OPIMM, 0, 0, 0, 7);
        #1 check("nf.rd0", 128'(stall), 128'd0);
        step("nf.opimm");
        id_instr(LOAD, 1, 2, 0, 4);
        step("nf.load_x4");
        id_instr(LUI, 0, 4, 4, 8);
        #1 check("nf.lui", 128'(stall), 128'd0);
        step("nf.lui_step");
        check("nf.lui_valid", 128'(ex_valid), 128'd1);

        // flush beats hazard
        id_instr(LOAD, 1, 2, 0, 3);
        step("fl.load");
        id_instr(RTYPE, 0, 3, 0, 9);
        flush = 1;
        #1 check("fl.stall", 128'(stall), 128'd0);
        step("fl.bubble");
        check("fl.valid", 128'(ex_valid), 128'd0);
        check("fl.cnt", 128'(cnt), 128'd1);

        // hold: outputs frozen while inputs wander
        id_instr(RTYPE, 0, 5, 6, 7);
        id_aluop = 2'b01;
        step("hold.pre");
        snap_c = m_ctrl();
        snap_d = {m.pc, m.rs1d, m.rs2d, m.imm};
        for (int i = 0; i < 3; i++) begin
            id_random();
            hold = 1; flush = 0;
            step("hold");
            check("hold.ctrl_frozen", dut_ctrl(), snap_c);
            check("hold.data_frozen", {ex_pc, ex_rs1d, ex_rs2d, ex_imm}, snap_d);
        end

        // asynchronous reset mid-cycle with a nonzero counter
        id_clear();
        #2 rst_n = 0;
        #1;
        check("areset.ctrl", dut_ctrl(), 128'd0);
        check("areset.data", {ex_pc, ex_rs1d, ex_rs2d, ex_imm}, 128'd0);
        check("areset.cnt", 128'(cnt), 128'd0);
        check("areset.stall", 128'(stall), 128'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // saturation of the narrow counter; wide one keeps counting
        for (int i = 0; i < 20; i++) begin
            id_instr(LOAD, 1, 1, 0, 2);
            step("sat.load");
            id_instr(RTYPE, 0, 2, 0, 10);
            step("sat.haz");
        end
        check("sat.cnt_s", 128'(s_cnt), 128'd15);
        check("sat.cnt", 128'(cnt), 128'd20);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            id_random();
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
